// File: rtl/timer_host_pkg.sv
// Shared definitions for the interval-timer host controller.
// Timer slave register map, control/status bit positions and FSM states.
// Optional snapshot states exist only when TIMER_HOST_SNAP_EN is defined.
package timer_host_pkg;

  // Timer slave word addresses
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  // Control register bit positions
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // Control register values written by the FSM
  localparam logic [15:0] CTRL_VAL_ONESHOT = 16'((1 << CTRL_ITO) | (1 << CTRL_START));
  localparam logic [15:0] CTRL_VAL_CONT    = 16'((1 << CTRL_ITO) | (1 << CTRL_CONT) | (1 << CTRL_START));
  localparam logic [15:0] CTRL_VAL_STOP    = 16'(1 << CTRL_STOP);

  // Status register bit positions
  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTRL,
    WAIT_IRQ,
    CLR_ST,
    RD_ST,
    RD_WAIT,
    WR_STOP
`ifdef TIMER_HOST_SNAP_EN
    ,
    WR_SNAP,
    RD_SNL,
    RD_SNL_WAIT,
    RD_SNH,
    RD_SNH_WAIT
`endif
  } state_t;

endpackage

// File: rtl/timer_host_ctrl_rd_lat.sv
// Read-capture strobe generator for a fixed-latency Avalon-MM slave.
// Latency: capture asserts exactly RD_LAT cycles after the issue strobe.
// No backpressure: the slave has no waitrequest, so the delay is fixed.
module avmm_rd_lat #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic issue,
  output logic capture
);

  logic [RD_LAT-1:0] dly;

  // Shift the read-issue strobe down an RD_LAT-deep delay line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dly <= '0;
    end else begin
      dly[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign capture = dly[RD_LAT-1];

endmodule

// File: rtl/timer_host_ctrl.sv
// Avalon-MM master that programs an interval timer, services its IRQ and counts timeouts.
// Bus outputs decode straight from the FSM state; one access per state, reads wait RD_LAT cycles.
// Optional macro TIMER_HOST_SNAP_EN adds a counter snapshot readout after each serviced timeout.
module timer_host_ctrl
  import timer_host_pkg::*;
#(
  parameter int TICK_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_continuous,
  output logic [2:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [15:0]       m_writedata,
  input  logic [15:0]       m_readdata,
  input  logic              irq_in,
  output logic              busy,
  output logic              tick_pulse,
  output logic [TICK_W-1:0] tick_count,
  output logic              oneshot_err,
  output logic [31:0]       snap_value,
  output logic              snap_valid
);

  state_t      state, nstate;
  state_t      after_tick;
  logic [31:0] period_q;
  logic        cont_q;
  logic        stop_pending;
  logic        rd_issue;
  logic        rd_cap;

  assign busy       = (state != IDLE);
  assign rd_issue   = m_chipselect && m_write_n;
  // A periodic timer keeps running; a one-shot must be checked for a stuck RUN bit
  assign after_tick = cont_q ? WAIT_IRQ : RD_ST;

  avmm_rd_lat #(.RD_LAT(RD_LAT)) u_rd_lat (
    .clk     (clk),
    .reset_n (reset_n),
    .issue   (rd_issue),
    .capture (rd_cap)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nstate;
  end

  // Next-state and bus access decode
  always_comb begin
    nstate       = state;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = ADDR_STATUS;
    m_writedata  = 16'h0000;
    tick_pulse   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) nstate = WR_PL;
      end
      WR_PL: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = ADDR_PERIODL;
        m_writedata  = period_q[15:0];
        nstate       = WR_PH;
      end
      WR_PH: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = ADDR_PERIODH;
        m_writedata  = period_q[31:16];
        nstate       = WR_CTRL;
      end
      // START goes last: each period write reloads and halts the slave
      WR_CTRL: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = ADDR_CONTROL;
        m_writedata  = cont_q ? CTRL_VAL_CONT : CTRL_VAL_ONESHOT;
        nstate       = WAIT_IRQ;
      end
      // A pending IRQ wins over a pending stop so no timeout is lost
      WAIT_IRQ: begin
        if (irq_in)            nstate = CLR_ST;
        else if (stop_pending) nstate = WR_STOP;
      end
      CLR_ST: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = ADDR_STATUS;
        tick_pulse   = 1'b1;
`ifdef TIMER_HOST_SNAP_EN
        nstate       = WR_SNAP;
`else
        nstate       = after_tick;
`endif
      end
      RD_ST: begin
        m_chipselect = 1'b1;
        m_address    = ADDR_STATUS;
        nstate       = RD_WAIT;
      end
      RD_WAIT: begin
        if (rd_cap) nstate = IDLE;
      end
      WR_STOP: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = ADDR_CONTROL;
        m_writedata  = CTRL_VAL_STOP;
        nstate       = IDLE;
      end
`ifdef TIMER_HOST_SNAP_EN
      WR_SNAP: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = ADDR_SNAPL;
        nstate       = RD_SNL;
      end
      RD_SNL: begin
        m_chipselect = 1'b1;
        m_address    = ADDR_SNAPL;
        nstate       = RD_SNL_WAIT;
      end
      RD_SNL_WAIT: begin
        if (rd_cap) nstate = RD_SNH;
      end
      RD_SNH: begin
        m_chipselect = 1'b1;
        m_address    = ADDR_SNAPH;
        nstate       = RD_SNH_WAIT;
      end
      RD_SNH_WAIT: begin
        if (rd_cap) nstate = after_tick;
      end
`endif
      default: nstate = IDLE;
    endcase
  end

  // Run configuration, stop request, tick counter and one-shot error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q     <= '0;
      cont_q       <= 1'b0;
      stop_pending <= 1'b0;
      tick_count   <= '0;
      oneshot_err  <= 1'b0;
    end else if (state == IDLE && cfg_start) begin
      period_q     <= cfg_period;
      cont_q       <= cfg_continuous;
      stop_pending <= 1'b0;
      tick_count   <= '0;
      oneshot_err  <= 1'b0;
    end else begin
      if (cfg_stop && state != IDLE) stop_pending <= 1'b1;
      else if (state == WR_STOP)     stop_pending <= 1'b0;
      if (state == CLR_ST) tick_count <= tick_count + TICK_W'(1);
      if (state == RD_WAIT && rd_cap && m_readdata[ST_RUN]) oneshot_err <= 1'b1;
    end
  end

`ifdef TIMER_HOST_SNAP_EN
  logic [15:0] snap_l;

  // Assemble the 32-bit snapshot from the two 16-bit reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_l     <= '0;
      snap_value <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= 1'b0;
      if (state == RD_SNL_WAIT && rd_cap) snap_l <= m_readdata;
      if (state == RD_SNH_WAIT && rd_cap) begin
        snap_value <= {m_readdata, snap_l};
        snap_valid <= 1'b1;
      end
    end
  end
`else
  logic unused_rd;
  assign unused_rd  = ^{m_readdata[15:ST_RUN+1], m_readdata[ST_TO]};
  assign snap_value = '0;
  assign snap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_timer_host_ctrl.sv
// Self-checking bench for timer_host_ctrl with a behavioural timer slave.
// Expected bus traffic is built from the access-sequence rules, not from the FSM.
// Covers directed cases from the test plan plus randomized runs.
module tb_timer_host_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [31:0] cfg_period = '0;
  logic        cfg_continuous = 1'b0;
  logic [2:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata = '0;
  logic        irq_in;
  logic        busy;
  logic        tick_pulse;
  logic [15:0] tick_count;
  logic        oneshot_err;
  logic [31:0] snap_value;
  logic        snap_valid;

  int errs = 0;
  int checks = 0;

  // slave model state
  logic        slv_to = 1'b0;
  logic        irq_req = 1'b0;
  logic [15:0] st_rb = 16'h0001;

  // monitor state: {is_read, addr, data}
  logic [19:0] obs[$];
  int          obs_ticks = 0;
  int          obs_snaps = 0;

  timer_host_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_period     (cfg_period),
    .cfg_continuous (cfg_continuous),
    .m_address      (m_address),
    .m_chipselect   (m_chipselect),
    .m_write_n      (m_write_n),
    .m_writedata    (m_writedata),
    .m_readdata     (m_readdata),
    .irq_in         (irq_in),
    .busy           (busy),
    .tick_pulse     (tick_pulse),
    .tick_count     (tick_count),
    .oneshot_err    (oneshot_err),
    .snap_value     (snap_value),
    .snap_valid     (snap_valid)
  );

  always #5 clk = ~clk;

  assign irq_in = slv_to;

  // Timer slave: TO set on request, cleared by any status write; 1-cycle read latency
  always @(posedge clk) begin
    if (m_chipselect && !m_write_n && m_address == 3'd0) slv_to <= 1'b0;
    else if (irq_req)                                    slv_to <= 1'b1;
    if (m_chipselect && m_write_n) begin
      case (m_address)
        3'd0:    m_readdata <= st_rb;
        3'd4:    m_readdata <= 16'h1234;
        3'd5:    m_readdata <= 16'h0000;
        default: m_readdata <= 16'h0000;
      endcase
    end
  end

  // Record every bus access and output pulse away from the active edge
  always @(negedge clk) begin
    if (reset_n) begin
      if (m_chipselect) obs.push_back({m_write_n, m_address, (m_write_n ? 16'h0000 : m_writedata)});
      if (tick_pulse) obs_ticks++;
      if (snap_valid) obs_snaps++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_case(input logic [31:0] per, input bit cont, input int n_irq,
                          input logic [15:0] rb, input int stop_mode);
    logic [19:0] exp_q[$];
    int          exp_ticks;
    bit          exp_err;
    int          t;
    logic [15:0] pl, ph;
    pl = per[15:0];
    ph = per[31:16];
    obs.delete();
    obs_ticks = 0;
    obs_snaps = 0;
    st_rb = rb;

    // expected traffic from the sequencing rules
    exp_q.push_back({1'b0, 3'd2, pl});
    exp_q.push_back({1'b0, 3'd3, ph});
    exp_q.push_back({1'b0, 3'd1, (cont ? 16'h0007 : 16'h0005)});
    if (stop_mode == 1) begin
      exp_q.push_back({1'b0, 3'd1, 16'h0008});
      exp_ticks = 0;
    end else begin
      for (int k = 0; k < n_irq; k++) begin
        exp_q.push_back({1'b0, 3'd0, 16'h0000});
`ifdef TIMER_HOST_SNAP_EN
        exp_q.push_back({1'b0, 3'd4, 16'h0000});
        exp_q.push_back({1'b1, 3'd4, 16'h0000});
        exp_q.push_back({1'b1, 3'd5, 16'h0000});
`endif
        if (!cont) exp_q.push_back({1'b1, 3'd0, 16'h0000});
      end
      if (cont) exp_q.push_back({1'b0, 3'd1, 16'h0008});
      exp_ticks = n_irq;
    end
    exp_err = (stop_mode != 1) && !cont && rb[1];

    // start and check the three config writes land on consecutive cycles
    cfg_period = per;
    cfg_continuous = cont;
    cfg_start = 1'b1;
    cyc(1);
    cfg_start = 1'b0;
    cfg_period = $urandom;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("wr_pl", {11'd0, m_chipselect, m_write_n, m_address, m_writedata}, {11'd0, 1'b1, 1'b0, 3'd2, pl});
    cyc(1);
    chk("wr_ph", {11'd0, m_chipselect, m_write_n, m_address, m_writedata}, {11'd0, 1'b1, 1'b0, 3'd3, ph});
    if (stop_mode == 1) cfg_stop = 1'b1;
    cyc(1);
    cfg_stop = 1'b0;
    chk("wr_ctrl", {11'd0, m_chipselect, m_write_n, m_address, m_writedata},
        {11'd0, 1'b1, 1'b0, 3'd1, (cont ? 16'h0007 : 16'h0005)});
    cyc(1);

    if (stop_mode != 1) begin
      // start while busy must be ignored
      cfg_start = 1'b1;
      cfg_period = 32'hDEAD_BEEF;
      cyc(1);
      cfg_start = 1'b0;
      for (int k = 0; k < n_irq; k++) begin
        if (stop_mode == 2 && k == n_irq - 1) cfg_stop = 1'b1;
        irq_req = 1'b1;
        cyc(1);
        irq_req = 1'b0;
        cfg_stop = 1'b0;
        cyc($urandom_range(3, 7));
      end
      if (cont && stop_mode == 0) begin
        cyc(10);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_tick_count", {16'd0, tick_count}, 32'(n_irq));
        cfg_stop = 1'b1;
        cyc(1);
        cfg_stop = 1'b0;
      end
    end

    t = 0;
    while (busy && t < 80) begin
      cyc(1);
      t++;
    end
    chk("idle_timeout", {31'd0, (t < 80)}, 32'd1);
    cyc(2);

    chk("n_bus", obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      chk($sformatf("bus%0d", i), {12'd0, obs[i]}, {12'd0, exp_q[i]});
    chk("ticks", obs_ticks, exp_ticks);
    chk("tick_count", {16'd0, tick_count}, 32'(exp_ticks));
    chk("oneshot_err", {31'd0, oneshot_err}, {31'd0, exp_err});
    chk("busy_end", {31'd0, busy}, 32'd0);
`ifdef TIMER_HOST_SNAP_EN
    chk("snap_pulses", obs_snaps, exp_ticks);
    if (exp_ticks > 0) chk("snap_value", snap_value, 32'h0000_1234);
`else
    chk("snap_pulses", obs_snaps, 0);
    chk("snap_value", snap_value, 32'd0);
`endif
  endtask

  initial begin
    bit          cont;
    logic [31:0] per;

    // reset state
    #1;
    chk("rst_cs", {31'd0, m_chipselect}, 32'd0);
    chk("rst_wn", {31'd0, m_write_n}, 32'd1);
    chk("rst_addr", {29'd0, m_address}, 32'd0);
    chk("rst_wdata", {16'd0, m_writedata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tick", {16'd0, tick_count}, 32'd0);
    chk("rst_err", {31'd0, oneshot_err}, 32'd0);
    chk("rst_snapv", {31'd0, snap_valid}, 32'd0);
    cyc(3);
    reset_n = 1'b1;
    cyc(2);

    // cfg_stop while idle: no traffic
    obs.delete();
    cfg_stop = 1'b1;
    cyc(1);
    cfg_stop = 1'b0;
    cyc(3);
    chk("idle_stop_bus", obs.size(), 0);
    chk("idle_stop_busy", {31'd0, busy}, 32'd0);

    // directed cases
    run_case(32'h0001_86A0, 1'b1, 3, 16'h0001, 0);
    run_case(32'd9, 1'b0, 1, 16'h0001, 0);
    run_case(32'd9, 1'b0, 1, 16'h0003, 0);
    run_case($urandom, 1'b1, 0, 16'h0001, 1);
    run_case($urandom, 1'b1, 2, 16'h0001, 2);

    // randomized cases
    for (int r = 0; r < 10; r++) begin
      cont = 1'($urandom_range(0, 1));
      per = $urandom;
      run_case(per, cont, (cont ? int'($urandom_range(1, 4)) : 1),
               ($urandom_range(0, 1) != 0) ? 16'h0003 : 16'h0001,
               int'($urandom_range(0, 2)));
    end

    // reset while waiting for an IRQ
    cfg_period = 32'd50;
    cfg_continuous = 1'b1;
    cfg_start = 1'b1;
    cyc(1);
    cfg_start = 1'b0;
    cyc(4);
    irq_req = 1'b1;
    cyc(1);
    irq_req = 1'b0;
    cyc(12);
    chk("pre_rst_tick", {16'd0, tick_count}, 32'd1);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cs", {31'd0, m_chipselect}, 32'd0);
    chk("mid_rst_wn", {31'd0, m_write_n}, 32'd1);
    chk("mid_rst_tick", {16'd0, tick_count}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/timer_host_ctrl.md
Name: timer_host_ctrl

Overview:
- Avalon-MM master that drives a 16-bit-data interval-timer slave: programs period, starts the timer, services its IRQ and counts timeouts.
- Sits between fabric control logic and the timer's s1 slave port; an IRQ-driven tick source that needs no CPU.
- Slave register map:
  - 0 status: bit0 TO, bit1 RUN; any write clears TO.
  - 1 control: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
  - 2 period_l, 3 period_h.
  - 4 snap_l, 5 snap_h; a write to either captures the counter.

Parameters:
- TICK_W, 16, width of tick counter.
- RD_LAT, 1, slave read latency in clk cycles; slave has no waitrequest.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_start  in  1  one-cycle start request
- cfg_stop  in  1  one-cycle stop request
- cfg_period  in  32  timer period, sampled on accepted cfg_start
- cfg_continuous  in  1  1 = periodic, 0 = one-shot; sampled with cfg_period
- m_address  out  3  slave word address
- m_chipselect  out  1  slave select
- m_write_n  out  1  active-low write
- m_writedata  out  16  write data
- m_readdata  in  16  slave read data
- irq_in  in  1  slave irq, level
- busy  out  1  FSM not in IDLE
- tick_pulse  out  1  one-cycle pulse per serviced timeout
- tick_count  out  TICK_W  serviced timeouts since last start, wraps
- oneshot_err  out  1  sticky; RUN still 1 after one-shot timeout; cleared on start
- snap_value  out  32  see Optional Feature
- snap_valid  out  1  see Optional Feature

Behaviour:
- Reset values: m_chipselect 0, m_write_n 1, m_address 0, m_writedata 0, busy 0, tick_pulse 0, tick_count 0, oneshot_err 0, snap_value 0, snap_valid 0. FSM in IDLE; stop_pending 0.
- Bus cycles:
  - A write occupies exactly one cycle: chipselect=1, write_n=0, address/data valid.
  - A read issues chipselect=1, write_n=1 for one cycle. m_readdata is captured RD_LAT cycles after the issue cycle.
  - Outside access cycles: chipselect=0, write_n=1.
- FSM states: IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, CLR_ST, RD_ST, RD_WAIT, WR_STOP.
  - IDLE: on cfg_start, latch period and continuous flag, clear tick_count/oneshot_err/stop_pending, go to WR_PL. cfg_start is ignored when busy.
  - WR_PL: write addr 2 = period[15:0], then WR_PH.
  - WR_PH: write addr 3 = period[31:16], then WR_CTRL.
  - WR_CTRL: write addr 1 = 0x0005 (one-shot) or 0x0007 (continuous), then WAIT_IRQ.
    - The START write must follow both period writes, because a period write force-reloads and stops the slave.
  - WAIT_IRQ: if irq_in, go to CLR_ST; else if stop_pending, go to WR_STOP.
  - CLR_ST: write addr 0 = 0x0000. In the same cycle pulse tick_pulse and increment tick_count (wraps at 2^TICK_W). Next state: continuous → WAIT_IRQ; one-shot → RD_ST.
  - RD_ST: read addr 0, then RD_WAIT.
  - RD_WAIT: wait RD_LAT cycles, capture m_readdata; if bit1=1, set oneshot_err. Then go to IDLE.
  - WR_STOP: write addr 1 = 0x0008, then IDLE.
- cfg_stop handling:
  - Accepted in any busy state; sets stop_pending.
  - stop_pending is acted on only in WAIT_IRQ, so a period/control sequence is never aborted mid-way.
  - cfg_stop in IDLE is ignored.
- Simultaneous irq_in and stop_pending in WAIT_IRQ: service the IRQ first (CLR_ST), then stop on the next WAIT_IRQ visit. Continuous mode only; one-shot finishes via RD_ST.
- irq_in stays high until the slave registers the status write, so the FSM never re-enters CLR_ST on the same event. WAIT_IRQ is entered at least 1 cycle after CLR_ST.
- Reset mid-operation: all outputs return to reset values immediately. The slave is reset independently.

Optional Feature:
- Macro: TIMER_HOST_SNAP_EN.
- Defined: after CLR_ST, add states WR_SNAP, RD_SNL, RD_SNL_WAIT, RD_SNH, RD_SNH_WAIT.
  - WR_SNAP: write addr 4.
  - RD_SNL / RD_SNL_WAIT: read addr 4.
  - RD_SNH / RD_SNH_WAIT: read addr 5.
  - Result: snap_value = {snap_h, snap_l}, with a one-cycle snap_valid pulse.
  - Then proceed as from CLR_ST (WAIT_IRQ or RD_ST).
- Undefined: those states are absent; snap_value = 0 and snap_valid = 0 constant.

Decomposition:
- Shared package timer_host_pkg:
  - Register addresses (ADDR_STATUS=0 … ADDR_SNAPH=5).
  - Control bit positions and values (CTRL_ITO, CTRL_CONT, CTRL_START, CTRL_STOP).
  - Status bits (ST_TO, ST_RUN).
  - FSM state enum.
- One natural sub-module, avmm_rd_lat: RD_LAT-deep shift-register delay of the read-issue strobe to generate the capture enable.

Test Plan:
- Start with period 0x0001_86A0, continuous=1 → writes addr2=0x86A0, addr3=0x0001, addr1=0x0007 on 3 consecutive cycles; busy=1.
- Continuous mode, slave model raises irq 3 times → 3 addr0 writes, tick_pulse ×3, tick_count=3, FSM back in WAIT_IRQ.
- One-shot, period 9, readback status=0x0001 → tick_count=1, oneshot_err=0, IDLE. Repeat with status readback 0x0003 → oneshot_err=1.
- cfg_stop during WR_PH → all three config writes complete, then addr1=0x0008, then IDLE. Same-cycle irq+stop → addr0 write precedes addr1=0x0008.
- cfg_start while busy → ignored, no extra writes. reset_n low during WAIT_IRQ → chipselect=0, write_n=1, tick_count=0.
- With TIMER_HOST_SNAP_EN, slave snap=0x0000_1234 → after CLR_ST: write addr4, reads addr4/addr5, snap_value=0x0000_1234, snap_valid pulses once.
